// File: rtl/conv_encoder_r4.sv
// conv_encoder_r4: radix-4, rate-1/2, K=3 convolutional encoder (g0=7, g1=5).
// Takes one 2-bit information pair per cycle and emits one registered 4-bit
// codeword. Each frame is FRAME_PAIRS pairs followed by one zero tail word,
// so every frame starts and ends in shift state 00.
// Optional build macro: ENC_ERR_INJ_EN adds i_err_mask, which is XORed into
// every loaded codeword (tail included) without touching the shift state.
module conv_encoder_r4 #(
  parameter int FRAME_PAIRS = 8,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_enc,
`ifdef ENC_ERR_INJ_EN
  input  logic [3:0] i_err_mask,
`endif
  input  logic       i_start,
  input  logic       i_valid,
  input  logic [1:0] i_data,
  output logic       o_ready,
  output logic [3:0] o_Tx,
  output logic       o_valid,
  output logic       o_last,
  input  logic       i_rdy,
  output logic       o_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ENC  = 2'd1,
    TAIL = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_PAIRS - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [1:0]       r_sh;       // {s1, s0}: s1 = previous bit, s0 = the one before
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_tx;
  logic             r_valid;
  logic             r_last;

  logic             w_slot_free;
  logic             w_ready;
  logic             w_accept;
  logic             w_load_tail;
  logic [5:0]       w_enc;      // {codeword, next state} for the input pair
  logic [5:0]       w_tail;     // {codeword, next state} for the zero tail pair
  logic [3:0]       w_mask;

  // Encode two bits in time order: u[1] first, then u[0] from the updated state.
  // Result is {c0a, c1a, c0b, c1b, s1', s0'}.
  function automatic logic [5:0] enc_pair(input logic [1:0] st, input logic [1:0] u);
    logic s1, s0, c0a, c1a, c0b, c1b;
    s1  = st[1];
    s0  = st[0];
    c0a = u[1] ^ s1 ^ s0;
    c1a = u[1] ^ s0;
    s0  = s1;
    s1  = u[1];
    c0b = u[0] ^ s1 ^ s0;
    c1b = u[0] ^ s0;
    s0  = s1;
    s1  = u[0];
    return {c0a, c1a, c0b, c1b, s1, s0};
  endfunction

  assign w_enc  = enc_pair(r_sh, i_data);
  assign w_tail = enc_pair(r_sh, 2'b00);

`ifdef ENC_ERR_INJ_EN
  assign w_mask = i_err_mask;
`else
  assign w_mask = 4'b0000;
`endif

  // The output register can take a new word when empty or being drained now.
  assign w_slot_free = !r_valid || i_rdy;

  // Next-state and handshake decode; enable gates every action.
  always_comb begin
    w_next_state = r_state;
    w_ready      = 1'b0;
    w_load_tail  = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) w_next_state = ENC;
      end
      ENC: begin
        w_ready = w_slot_free;
        if (i_valid && w_slot_free && (r_cnt == LAST_CNT)) w_next_state = TAIL;
      end
      TAIL: begin
        if (w_slot_free) begin
          w_load_tail  = 1'b1;
          w_next_state = DONE;
        end
      end
      DONE: begin
        if (r_valid && i_rdy) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  assign o_ready  = en_enc && w_ready;
  assign w_accept = o_ready && i_valid;

  // FSM, shift state, pair counter and output register; frozen while en_enc=0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_sh    <= 2'b00;
      r_cnt   <= '0;
      r_tx    <= 4'b0000;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else if (en_enc) begin
      r_state <= w_next_state;
      if (r_state == IDLE && i_start) begin
        r_cnt <= '0;
        r_sh  <= 2'b00;
      end
      if (w_accept) begin
        r_tx    <= w_enc[5:2] ^ w_mask;
        r_valid <= 1'b1;
        r_last  <= 1'b0;
        r_sh    <= w_enc[1:0];
        r_cnt   <= r_cnt + 1'b1;
      end else if (w_load_tail) begin
        r_tx    <= w_tail[5:2] ^ w_mask;
        r_valid <= 1'b1;
        r_last  <= 1'b1;
        r_sh    <= 2'b00;
      end else if (r_valid && i_rdy) begin
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end
    end
  end

  assign o_Tx    = r_tx;
  assign o_valid = r_valid;
  assign o_last  = r_last;
  assign o_busy  = (r_state != IDLE);

endmodule

// File: tb/tb_conv_encoder_r4.sv
// tb_conv_encoder_r4: randomized bench for conv_encoder_r4 with a bit-level
// generator-polynomial reference model and an output scoreboard.
module tb_conv_encoder_r4;

  localparam int FP = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en_enc = 1'b1;
  logic       i_start = 1'b0;
  logic       i_valid = 1'b0;
  logic [1:0] i_data = 2'b00;
  logic       i_rdy = 1'b1;
  logic       o_ready, o_valid, o_last, o_busy;
  logic [3:0] o_Tx;
`ifdef ENC_ERR_INJ_EN
  logic [3:0] i_err_mask = 4'b0000;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [1:0] stim_q[$];   // pairs still to be accepted
  logic [4:0] exp_q[$];    // expected {last, codeword}

  always #5 clk = ~clk;

  conv_encoder_r4 #(.FRAME_PAIRS(FP), .CNT_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .en_enc(en_enc),
`ifdef ENC_ERR_INJ_EN
    .i_err_mask(i_err_mask),
`endif
    .i_start(i_start),
    .i_valid(i_valid),
    .i_data(i_data),
    .o_ready(o_ready),
    .o_Tx(o_Tx),
    .o_valid(o_valid),
    .o_last(o_last),
    .i_rdy(i_rdy),
    .o_busy(o_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: flatten the frame into a bit stream (earlier bit first), append
  // two zero tail bits, and apply c0 = u(n)^u(n-1)^u(n-2), c1 = u(n)^u(n-2).
  task automatic model_frame(input logic [1:0] pairs[$]);
    bit b[$];
    foreach (pairs[k]) begin
      b.push_back(pairs[k][1]);
      b.push_back(pairs[k][0]);
    end
    b.push_back(1'b0);
    b.push_back(1'b0);
    for (int w = 0; w <= pairs.size(); w++) begin
      logic [3:0] cw;
      for (int j = 0; j < 2; j++) begin
        int n;
        bit u, u1, u2;
        n  = 2 * w + j;
        u  = b[n];
        u1 = (n >= 1) ? b[n-1] : 1'b0;
        u2 = (n >= 2) ? b[n-2] : 1'b0;
        cw[3-2*j] = u ^ u1 ^ u2;
        cw[2-2*j] = u ^ u2;
      end
      exp_q.push_back({(w == pairs.size()), cw});
      if (w < pairs.size()) stim_q.push_back(pairs[w]);
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while (o_busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("idle_timeout", {31'd0, o_busy}, 32'd0);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    en_enc  = 1'b1;
    i_start = 1'b1;
    i_valid = (stim_q.size() > 0);
    i_data  = (stim_q.size() > 0) ? stim_q[0] : 2'b00;
    i_rdy   = 1'b1;
    #1;
    chk("ready_in_idle", {31'd0, o_ready}, 32'd0);
    @(negedge clk);
    i_start = 1'b0;
    chk("busy_after_start", {31'd0, o_busy}, 32'd1);
  endtask

  // Drive one frame with random valid/ready/enable and check every handshake.
  task automatic run_frame(input int rdy_pct, input int en_pct, input int vld_pct, input bit inj_first);
    int   budget = 0;
    bit   prev_stall = 1'b0, prev_frozen = 1'b0;
    logic [3:0] p_tx;
    logic p_valid, p_last, p_busy;
    logic [4:0] e;
    pulse_start();
    while ((stim_q.size() > 0 || exp_q.size() > 0) && budget < 500) begin
      budget++;
      if (budget > 1) @(negedge clk);
      if (prev_stall) begin
        chk("hold_valid", {31'd0, o_valid}, 32'd1);
        chk("hold_tx", {28'd0, o_Tx}, {28'd0, p_tx});
        chk("hold_last", {31'd0, o_last}, {31'd0, p_last});
      end
      if (prev_frozen) begin
        chk("frz_tx", {28'd0, o_Tx}, {28'd0, p_tx});
        chk("frz_valid", {31'd0, o_valid}, {31'd0, p_valid});
        chk("frz_last", {31'd0, o_last}, {31'd0, p_last});
        chk("frz_busy", {31'd0, o_busy}, {31'd0, p_busy});
      end
      p_tx = o_Tx; p_valid = o_valid; p_last = o_last; p_busy = o_busy;
      en_enc  = ($urandom_range(99) < en_pct);
      i_rdy   = ($urandom_range(99) < rdy_pct);
      i_valid = (stim_q.size() > 0) && ($urandom_range(99) < vld_pct);
      i_data  = (stim_q.size() > 0) ? stim_q[0] : 2'($urandom_range(3));
`ifdef ENC_ERR_INJ_EN
      i_err_mask = (inj_first && stim_q.size() == FP) ? 4'b1000 : 4'b0000;
`endif
      #1;
      if (!en_enc) chk("ready_when_disabled", {31'd0, o_ready}, 32'd0);
      if (o_valid && !i_rdy) chk("ready_when_stalled", {31'd0, o_ready}, 32'd0);
      if (en_enc && o_valid && i_rdy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", {27'd0, o_last, o_Tx}, 32'hFFFF);
        end else begin
          e = exp_q.pop_front();
          chk("tx", {28'd0, o_Tx}, {28'd0, e[3:0]});
          chk("last", {31'd0, o_last}, {31'd0, e[4]});
        end
      end
      if (en_enc && i_valid && o_ready) void'(stim_q.pop_front());
      prev_stall  = en_enc && o_valid && !i_rdy;
      prev_frozen = !en_enc;
    end
    chk("frame_timeout", budget, (budget < 500) ? budget : 0);
    @(negedge clk);
    en_enc = 1'b1; i_valid = 1'b0; i_rdy = 1'b1;
`ifdef ENC_ERR_INJ_EN
    i_err_mask = 4'b0000;
`endif
    stim_q.delete();
    exp_q.delete();
  endtask

  task automatic directed(input logic [1:0] p0, input logic [1:0] p1,
                          input logic [3:0] w0, input logic [3:0] w1, input logic [3:0] wt,
                          input int rdy_pct);
    wait_idle();
    stim_q.push_back(p0); stim_q.push_back(p1);
    exp_q.push_back({1'b0, w0}); exp_q.push_back({1'b0, w1}); exp_q.push_back({1'b1, wt});
    run_frame(rdy_pct, 100, 100, 1'b0);
  endtask

  initial begin
    logic [1:0] pr[$];
    int t;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_tx", {28'd0, o_Tx}, 32'd0);
    chk("rst_last", {31'd0, o_last}, 32'd0);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_ready", {31'd0, o_ready}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Hand-computed frames, unstalled and with backpressure
    directed(2'b11, 2'b00, 4'b1101, 4'b0111, 4'b0000, 100);
    directed(2'b10, 2'b00, 4'b1110, 4'b1100, 4'b0000, 100);
    directed(2'b11, 2'b11, 4'b1101, 4'b1010, 4'b0111, 100);
    directed(2'b11, 2'b00, 4'b1101, 4'b0111, 4'b0000, 40);

    // Random frames against the model with random ready, valid and enable
    for (int f = 0; f < 30; f++) begin
      wait_idle();
      pr.delete();
      for (int k = 0; k < FP; k++) pr.push_back(2'($urandom_range(3)));
      model_frame(pr);
      run_frame(60 + $urandom_range(40), (f < 5) ? 100 : 80, 75, 1'b0);
    end

    // Reset while a word is pending mid-frame
    wait_idle();
    stim_q.push_back(2'b01); stim_q.push_back(2'b10);
    pulse_start();
    i_valid = 1'b1; i_data = stim_q[0]; i_rdy = 1'b0;
    t = 0;
    while (!o_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("mid_valid_seen", {31'd0, o_valid}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("mid_rst_valid", {31'd0, o_valid}, 32'd0);
    chk("mid_rst_tx", {28'd0, o_Tx}, 32'd0);
    chk("mid_rst_busy", {31'd0, o_busy}, 32'd0);
    chk("mid_rst_ready", {31'd0, o_ready}, 32'd0);
    rst = 1'b1; i_valid = 1'b0; i_rdy = 1'b1;
    stim_q.delete();
    @(negedge clk);

    // Encoder recovers cleanly from the aborted frame
    directed(2'b11, 2'b00, 4'b1101, 4'b0111, 4'b0000, 100);

`ifdef ENC_ERR_INJ_EN
    wait_idle();
    stim_q.push_back(2'b11); stim_q.push_back(2'b00);
    exp_q.push_back({1'b0, 4'b0101}); exp_q.push_back({1'b0, 4'b0111}); exp_q.push_back({1'b1, 4'b0000});
    run_frame(100, 100, 100, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
